// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a request-to-send, shifts one byte, parity and
// stop bit out on device clock edges, then checks for the device ACK.
// Every failure path releases both lines and reports a 2-bit error code.
`timescale 1ns/1ps

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned START_TIMEOUT  = 1500000,
    parameter int unsigned PACKET_TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    // One shared timer covers inhibit, start timeout and packet timeout,
    // since those intervals never overlap.
    localparam int unsigned MAX_AB = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int unsigned MAX_T  = (MAX_AB > PACKET_TIMEOUT) ? MAX_AB : PACKET_TIMEOUT;
    localparam int unsigned CNT_W  = $clog2(MAX_T + 1);
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned SH_W   = 9;

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PKT_LAST   = CNT_W'(PACKET_TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_START  = 2'b01;
    localparam logic [1:0] ERR_PACKET = 2'b10;
    localparam logic [1:0] ERR_NOACK  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d, bit_inc;
    logic [SH_W-1:0]   sh, sh_d;
    logic              clk_oe_d, data_oe_d;
    logic              tx_ready_d, done_d, err_d;
    logic [1:0]        err_code_d;
    logic              pkt_expired;
    logic              abort;
    logic [1:0]        abort_code;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic fall;

    // Two-flop synchronizers plus one history flop for clock edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            sh          <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            bit_cnt     <= bit_cnt_d;
            sh          <= sh_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            tx_ready    <= tx_ready_d;
            done        <= done_d;
            err         <= err_d;
            err_code    <= err_code_d;
        end
    end

    // Next-state and next-output logic; aborts are collected and applied last.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bit_cnt_d   = bit_cnt;
        sh_d        = sh;
        clk_oe_d    = ps2_clk_oe;
        data_oe_d   = ps2_data_oe;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code;
        abort       = 1'b0;
        abort_code  = ERR_NONE;
        cnt_inc     = cnt + CNT_W'(1);
        bit_inc     = (bit_cnt == '1) ? bit_cnt : bit_cnt + BIT_W'(1);
        pkt_expired = (cnt >= PKT_LAST);

        case (state)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    // Odd parity: the parity bit makes the total count of ones odd.
                    sh_d       = {~^tx_data, tx_data};
                    err_code_d = ERR_NONE;
                    cnt_d      = '0;
                    bit_cnt_d  = '0;
                    state_d    = S_INHIBIT;
                    clk_oe_d   = 1'b1;
                    data_oe_d  = (INH_LAST == '0);
                end
            end

            S_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    // Clock released, data stays low as the start bit.
                    state_d   = S_REQ;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d     = cnt_inc;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (cnt_inc == INH_LAST);
                end
            end

            S_REQ: begin
                if (fall) begin
                    // First device edge: put bit 0 on the line, start packet timer.
                    state_d   = S_SHIFT;
                    data_oe_d = ~sh[0];
                    sh_d      = {1'b1, sh[SH_W-1:1]};
                    bit_cnt_d = bit_inc;
                    cnt_d     = '0;
                end else if (cnt == START_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_START;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_SHIFT: begin
                if (pkt_expired) begin
                    abort      = 1'b1;
                    abort_code = ERR_PACKET;
                end else begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        // Register refills with ones, so edge 10 drives the stop bit.
                        data_oe_d = ~sh[0];
                        sh_d      = {1'b1, sh[SH_W-1:1]};
                        bit_cnt_d = bit_inc;
                        if (bit_cnt == BIT_W'(9)) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end

            S_ACK: begin
                if (fall) begin
                    bit_cnt_d = bit_inc;
                    if (!data_sync) begin
                        state_d = S_WAIT_IDLE;
                        cnt_d   = cnt_inc;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_NOACK;
                    end
                end else if (pkt_expired) begin
                    abort      = 1'b1;
                    abort_code = ERR_PACKET;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_WAIT_IDLE: begin
                // Further clock edges are ignored; only bus-idle matters here.
                if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (pkt_expired) begin
                    abort      = 1'b1;
                    abort_code = ERR_PACKET;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d   = S_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            err_d      = 1'b1;
            err_code_d = abort_code;
        end

        tx_ready_d = (state_d == S_IDLE);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int unsigned INH      = 2000;
    localparam int unsigned START_TO = 1000;
    localparam int unsigned PKT_TO   = 5000;
    localparam int unsigned HALF     = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, done, err;
    logic [1:0] err_code;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int errors = 0;

    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int start_cnt = 0;
    logic clk_oe_q = 1'b0;

    logic [7:0] vb [4] = '{8'hED, 8'h00, 8'h01, 8'h7F};
    logic       vp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    // Open-drain bus: a line is low if either side pulls it.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (START_TO),
        .PACKET_TIMEOUT(PKT_TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    // Pulse and transfer-start counters.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (ps2_clk_oe && !clk_oe_q) start_cnt++;
        clk_oe_q = ps2_clk_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic measure_inhibit(output int low, output int start_bits, output logic last_d);
        low = 0;
        start_bits = 0;
        last_d = 1'b0;
        while (ps2_clk_oe && low < int'(INH) + 100) begin
            low++;
            if (ps2_data_oe) start_bits++;
            last_d = ps2_data_oe;
            @(negedge clk);
        end
    endtask

    // Device: waits for request-to-send, clocks n_edges, samples data before each rising edge.
    task automatic run_device(input int n_edges, input logic ack, output logic [9:0] bits);
        int w;
        bits = '0;
        w = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < int'(INH) + 200) begin
            w++;
            @(negedge clk);
        end
        check("start_bit_seen", 32'(ps2_data_oe & ~ps2_clk_oe), 1);
        tick(10);
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11) begin
                dev_data_low = ack;
                tick(5);
            end
            dev_clk_low = 1'b1;
            tick(HALF);
            if (e <= 10) bits[e-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (e == 11) dev_data_low = 1'b0;
            tick(HALF);
        end
    endtask

    task automatic wait_ready(input string tag, input int max);
        int w;
        w = 0;
        while (!tx_ready && w < max) begin
            w++;
            @(negedge clk);
        end
        check(tag, 32'(tx_ready), 1);
    endtask

    task automatic xfer_ok(input string tag, input logic [7:0] b, input logic par, input logic meas);
        int d0, e0, low, sb;
        logic last_d;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        check({tag, "_code_clr"}, 32'(err_code), 0);
        if (meas) begin
            measure_inhibit(low, sb, last_d);
            check({tag, "_inhibit_len"}, 32'(low), INH);
            check({tag, "_start_cycles"}, 32'(sb), 1);
            check({tag, "_start_last"}, 32'(last_d), 1);
        end
        run_device(11, 1'b1, bits);
        wait_ready({tag, "_ready"}, 100);
        tick(2);
        check({tag, "_data"}, 32'(bits[7:0]), 32'(b));
        check({tag, "_parity"}, 32'(bits[8]), 32'(par));
        check({tag, "_stop"}, 32'(bits[9]), 1);
        check({tag, "_done"}, 32'(done_cnt - d0), 1);
        check({tag, "_err"}, 32'(err_cnt - e0), 0);
        check({tag, "_code"}, 32'(err_code), 0);
    endtask

    // Hang guard.
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, s0, c, low, sb;
        logic last_d;
        logic [9:0] bits;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick(3);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_code", 32'(err_code), 0);
        reset = 1'b0;
        tick(5);

        // Normal sends; first one also checks inhibit timing and start bit.
        for (int i = 0; i < 4; i++) begin
            xfer_ok($sformatf("send%0d", i), vb[i], vp[i], (i == 0));
            tick(10);
        end

        // Device leaves data high at edge 11.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h5A);
        run_device(11, 1'b0, bits);
        wait_ready("noack_ready", 100);
        tick(2);
        check("noack_err", 32'(err_cnt - e0), 1);
        check("noack_done", 32'(done_cnt - d0), 0);
        check("noack_code", 32'(err_code), 32'(2'b11));
        check("noack_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        tick(5);
        check("noack_code_held", 32'(err_code), 32'(2'b11));
        check("noack_err_1cyc", 32'(err), 0);

        // Device stops after edge 5.
        d0 = done_cnt;
        start_tx(8'h3C);
        check("pkt_code_clr", 32'(err_code), 0);
        run_device(5, 1'b1, bits);
        check("pkt_bits", 32'(bits[4:0]), 32'(5'b11100));
        c = 0;
        while (!err && c < int'(PKT_TO) + 100) begin
            c++;
            @(negedge clk);
        end
        check("pkt_err", 32'(err), 1);
        check("pkt_code", 32'(err_code), 32'(2'b10));
        check("pkt_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("pkt_ready", 32'(tx_ready), 1);
        check("pkt_done", 32'(done_cnt - d0), 0);
        tick(10);

        // Silent device: count from clock release to err.
        start_tx(8'hA5);
        measure_inhibit(low, sb, last_d);
        c = 0;
        while (!err && c < int'(START_TO) + 100) begin
            @(negedge clk);
            c++;
        end
        check("sto_delay", 32'(c), START_TO);
        check("sto_code", 32'(err_code), 32'(2'b01));
        check("sto_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("sto_ready", 32'(tx_ready), 1);
        tick(1);
        check("sto_err_1cyc", 32'(err), 0);
        tick(10);

        // Reset while bit 4 (a zero) is being driven.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h0F);
        run_device(5, 1'b1, bits);
        check("rsh_pre_data_oe", 32'(ps2_data_oe), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rsh_clk_oe", 32'(ps2_clk_oe), 0);
        check("rsh_data_oe", 32'(ps2_data_oe), 0);
        check("rsh_ready", 32'(tx_ready), 1);
        check("rsh_done", 32'(done), 0);
        check("rsh_err", 32'(err), 0);
        reset = 1'b0;
        tick(20);
        check("rsh_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 0);

        // Second request during INHIBIT is dropped.
        d0 = done_cnt;
        s0 = start_cnt;
        start_tx(8'hA5);
        tick(100);
        check("dbl_busy", 32'(tx_ready), 0);
        start_tx(8'h33);
        run_device(11, 1'b1, bits);
        check("dbl_data", 32'(bits[7:0]), 32'(8'hA5));
        check("dbl_parity", 32'(bits[8]), 1);
        wait_ready("dbl_ready", 100);
        tick(INH + 500);
        check("dbl_starts", 32'(start_cnt - s0), 1);
        check("dbl_done", 32'(done_cnt - d0), 1);
        check("dbl_idle", 32'(tx_ready), 1);

        check("done_err_overlap", 32'(both_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
